uart_rx: RTL and testbench

UART receiver, the receive-side counterpart of the board's UART transmit path. It samples the serial `UART_RX` pin in the `sysclk` domain and recovers 8N1 frames, 8-bit data, LSB first. It presents each byte through a one-entry valid/ready holding register and reports framing and overrun errors. It sits between the board pin and the top-level consumer logic in `z1top`.

---
 rtl/uart_rx.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- UART receiver for the sysclk domain.
//
// Recovers 8N1 frames (8 data bits, LSB first) from the asynchronous UART_RX
// pin. Each byte goes into a one-entry valid/ready holding register. Framing
// and overrun errors are reported as one-cycle pulses.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 8E1 frames. An even-parity bit follows the data bits, and
//                parity_err pulses at the stop sample on a mismatch.
//   undefined -> 8N1 frames. parity_err is tied to 0.
//
// Parameters
//   CLK_HZ        sysclk frequency in Hz
//   BAUD          line rate in bits per second
//   CLKS_PER_BIT  sysclk cycles per bit (>= 4), default CLK_HZ/BAUD
//
// Ports
//   sysclk      in   single rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   UART_RX     in   serial line, idle high, asynchronous to sysclk
//   data_out    out  [7:0] received byte, valid while data_valid is high
//   data_valid  out  holding register full
//   data_ready  in   consumer takes the byte when data_valid && data_ready
//   busy        out  receiver FSM is not idle
//   frame_err   out  one-cycle pulse: stop bit sampled low
//   overrun     out  one-cycle pulse: completed byte dropped, register full
//   parity_err  out  one-cycle pulse: parity mismatch (parity builds only)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_HZ       = 125_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       UART_RX,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  // Start-bit centre: half a bit after the falling edge was seen.
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  // Every later bit is sampled one full bit period after the previous centre.
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // Registered state and datapath
  // ---------------------------------------------------------------------------
  logic          rx_meta;       // first synchronizer stage
  logic          rx_s;          // synchronized line; the only view the FSM uses
  state_t        state_q,     state_nxt;
  logic [CW-1:0] cnt_q,       cnt_nxt;
  logic [2:0]    bit_idx_q,   bit_idx_nxt;
  logic [7:0]    shreg_q,     shreg_nxt;
  logic [7:0]    data_q,      data_nxt;
  logic          valid_q,     valid_nxt;
  logic          frame_err_q, frame_err_nxt;
  logic          overrun_q,   overrun_nxt;
  logic          commit;        // stop bit good: byte heads for the holding register
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q,    par_bad_nxt;
  logic          parity_err_q, parity_err_nxt;
`endif

  // ---------------------------------------------------------------------------
  // Process 1: state register (plus synchronizer and datapath flops)
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments. Every flop then samples
  // the pre-edge values, and the order of statements cannot change behaviour.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      // The synchronizer resets to the idle level. Coming out of reset it then
      // cannot present a false start bit.
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta      <= UART_RX;
      rx_s         <= rx_meta;
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      bit_idx_q    <= bit_idx_nxt;
      shreg_q      <= shreg_nxt;
      data_q       <= data_nxt;
      valid_q      <= valid_nxt;
      frame_err_q  <= frame_err_nxt;
      overrun_q    <= overrun_nxt;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_nxt;
      parity_err_q <= parity_err_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state and datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default first. No path can leave one unassigned,
  // so no latch is inferred.
  always_comb begin
    state_nxt      = state_q;
    cnt_nxt        = cnt_q;
    bit_idx_nxt    = bit_idx_q;
    shreg_nxt      = shreg_q;
    data_nxt       = data_q;
    valid_nxt      = valid_q;
    frame_err_nxt  = 1'b0;
    overrun_nxt    = 1'b0;
    commit         = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt    = par_bad_q;
    parity_err_nxt = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt = S_START;
          cnt_nxt   = '0;
        end
      end

      S_START: begin
        if (cnt_q == HALF) begin
          // Recheck at the start-bit centre. If the line is high again, the
          // low level was only a glitch.
          if (rx_s) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt   = S_DATA;
            cnt_nxt     = '0;
            bit_idx_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == LAST) begin
          // LSB arrives first. After eight right shifts it sits in bit 0.
          shreg_nxt   = {rx_s, shreg_q[7:1]};
          cnt_nxt     = '0;
          bit_idx_nxt = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == LAST) begin
          // Even parity: data bits plus the parity bit hold an even number of ones.
          par_bad_nxt = rx_s ^ (^shreg_q);
          cnt_nxt     = '0;
          state_nxt   = S_STOP;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
`endif

      S_STOP: begin
        if (cnt_q == LAST) begin
          // Return to IDLE at the stop-bit centre. The remaining half bit then
          // absorbs clock mismatch, so back-to-back frames are received.
          state_nxt     = S_IDLE;
          cnt_nxt       = '0;
          frame_err_nxt = ~rx_s;
`ifdef UART_RX_PARITY_EN
          parity_err_nxt = par_bad_q;
          commit         = rx_s & ~par_bad_q;
`else
          commit         = rx_s;
`endif
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    // Holding register. When data_ready is high on a commit edge, the old byte
    // leaves and the new byte enters on the same edge, so data_valid stays high.
    if (commit) begin
      if (!valid_q || data_ready) begin
        data_nxt  = shreg_q;
        valid_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_nxt = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 3: outputs. Every output comes straight from a flop or from a
  // decode of the registered state.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy       = (state_q != S_IDLE);
    data_out   = data_q;
    data_valid = valid_q;
    frame_err  = frame_err_q;
    overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    parity_err = parity_err_q;
`else
    parity_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at CLKS_PER_BIT = 8.
// The stimulus pushes expected bytes into a scoreboard queue. A monitor pops
// one byte and compares it on every data_valid && data_ready handshake. Error
// pulses are counted, and each scenario checks how the counts change.
// Inputs change 1 time unit after a rising edge. Outputs are read either on
// the falling edge (monitor) or 1 unit after a rising edge (stimulus thread).
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB = 8;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       uart_line;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .UART_RX    (uart_line),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 sysclk = ~sysclk;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  sb[$];
  logic [31:0] sb_exp;
  int          n_frame = 0, n_over = 0, n_par = 0, n_vcyc = 0;
  logic        prev_valid = 1'b0;
  longint      t_start = 0, t_valid = 0;
  int          f0, o0, p0, v0, bc, lat;
  logic [7:0]  b55;
  logic [7:0]  rnd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_line = v;
    tick(CPB);
  endtask

  task automatic send_head(input logic [7:0] b);
    t_start = $time;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_raw(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    send_head(b);
    drive_bit(par_bit);
    drive_bit(stop_bit);
    uart_line = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    send_raw(b, stop_bit, ^b);
  endtask
`else
  task automatic send(input logic [7:0] b, input logic stop_bit);
    send_head(b);
    drive_bit(stop_bit);
    uart_line = 1'b1;
  endtask
`endif

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && sb.size() != 0; i++) tick(1);
    check(tag, sb.size(), 0);
  endtask

  task automatic snap();
    f0 = n_frame; o0 = n_over; p0 = n_par; v0 = n_vcyc;
  endtask

  // Monitor: count pulses and score every accepted byte.
  always @(negedge sysclk) begin
    if (rst_n) begin
      if (frame_err)  n_frame++;
      if (overrun)    n_over++;
      if (parity_err) n_par++;
      if (data_valid) n_vcyc++;
      if (data_valid && !prev_valid) t_valid = $time;
      if (data_valid && data_ready) begin
        sb_exp = (sb.size() != 0) ? {24'h0, sb.pop_front()} : 32'hDEAD_BEEF;
        check("accepted_byte", {24'h0, data_out}, sb_exp);
      end
    end
    prev_valid = data_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    uart_line  = 1'b1;
    data_ready = 1'b1;
    rst_n      = 1'b0;
    tick(3);
    check("rst_data_out",   {24'h0, data_out}, 32'h00);
    check("rst_data_valid", data_valid, 0);
    check("rst_busy",       busy, 0);
    check("rst_frame_err",  frame_err, 0);
    check("rst_overrun",    overrun, 0);
    check("rst_parity_err", parity_err, 0);
    rst_n = 1'b1;
    tick(4);

    // 0xA5 with consumer always ready: one-cycle valid, nominal latency.
    snap();
    sb.push_back(8'hA5);
    send(8'hA5, 1'b1);
    tick(6);
    wait_drain("a5_drain");
    check("a5_valid_cycles", n_vcyc - v0, 1);
    lat = int'((t_valid - t_start) / 10);
    check("a5_latency_in_range", (lat >= 3 + 3 + 1 + 9 * CPB - 1 + ((CPB > 0) ? 0 : 0) &&
                                  lat <= 3 + 3 + 1 + 9 * CPB + 1 + 8 * 0 +
`ifdef UART_RX_PARITY_EN
                                  CPB
`else
                                  0
`endif
                                  ), 1);
    check("a5_no_frame_err", n_frame - f0, 0);
    check("a5_no_overrun",   n_over - o0, 0);
    check("a5_no_parity",    n_par - p0, 0);

    // Two-cycle low glitch on an idle line: short busy, nothing else.
    snap();
    uart_line = 1'b0;
    tick(2);
    uart_line = 1'b1;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (busy) bc++;
    end
    check("glitch_busy_short", (bc >= 1 && bc <= 5), 1);
    check("glitch_busy_idle",  busy, 0);
    check("glitch_no_valid",   n_vcyc - v0, 0);
    check("glitch_no_frame",   n_frame - f0, 0);

    // 0x3C with a low stop bit: one frame error, no byte.
    snap();
    send(8'h3C, 1'b0);
    tick(12);
    check("stop0_frame_err", n_frame - f0, 1);
    check("stop0_no_valid",  n_vcyc - v0, 0);

    // Consumer stalled, two frames back-to-back: the second byte overruns.
    snap();
    data_ready = 1'b0;
    sb.push_back(8'h11);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    tick(4);
    check("ovr_valid_held", data_valid, 1);
    check("ovr_data_kept",  {24'h0, data_out}, 32'h11);
    check("ovr_pulse",      n_over - o0, 1);
    data_ready = 1'b1;
    tick(1);
    check("ovr_cleared", data_valid, 0);
    wait_drain("ovr_drain");

    // Reset in the middle of bit 4 of 0x55 while a byte is held.
    data_ready = 1'b0;
    sb.push_back(8'h99);
    send(8'h99, 1'b1);
    tick(4);
    check("held_before_rst", data_valid, 1);
    b55 = 8'h55;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b55[i]);
    uart_line = b55[4];
    tick(CPB / 2);
    check("mid_frame_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    check("arst_data_out",   {24'h0, data_out}, 32'h00);
    check("arst_data_valid", data_valid, 0);
    check("arst_busy",       busy, 0);
    check("arst_flags",      {29'h0, frame_err, overrun, parity_err}, 0);
    sb.delete();
    uart_line = 1'b1;
    tick(3);
    rst_n      = 1'b1;
    data_ready = 1'b1;
    tick(3);
    sb.push_back(8'h0F);
    send(8'h0F, 1'b1);
    tick(4);
    wait_drain("post_rst_drain");

    // A few random bytes back-to-back with the consumer ready.
    snap();
    for (int i = 0; i < 4; i++) begin
      rnd = 8'($urandom_range(0, 255));
      sb.push_back(rnd);
      send(rnd, 1'b1);
    end
    tick(6);
    wait_drain("burst_drain");
    check("burst_valid_cycles", n_vcyc - v0, 4);
    check("burst_no_errors",    (n_frame - f0) + (n_over - o0) + (n_par - p0), 0);

`ifdef UART_RX_PARITY_EN
    // Wrong parity for 0x07 (three ones needs parity 1): byte discarded.
    snap();
    send_raw(8'h07, 1'b1, 1'b0);
    tick(6);
    check("par_bad_pulse",    n_par - p0, 1);
    check("par_bad_no_valid", n_vcyc - v0, 0);
    check("par_bad_no_frame", n_frame - f0, 0);
    sb.push_back(8'h07);
    send_raw(8'h07, 1'b1, 1'b1);
    tick(6);
    wait_drain("par_ok_drain");
    check("par_ok_no_err", n_par - p0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
